// File: rtl/prt_scaler_krnl_ctl_if.sv
// Window/tap handshake bundle between the line-buffer loader, the kernel
// sequencer and the kernel mux/MAC.
interface prt_scaler_krnl_ctl_if #(
  parameter int P_FRAC = 8
);
  logic [P_FRAC+1:0] STEP_IN;
  logic              SOL_IN;
  logic              WIN_VLD_IN;
  logic              WIN_RDY_OUT;
  logic              DST_RDY_IN;
  logic              VLD_OUT;
  logic [3:0]        SEL_OUT;
  logic [1:0]        TAP_OUT;
  logic [P_FRAC-1:0] PHASE_OUT;
  logic              LAST_OUT;

  modport master (
    input  STEP_IN, SOL_IN, WIN_VLD_IN, DST_RDY_IN,
    output WIN_RDY_OUT, VLD_OUT, SEL_OUT, TAP_OUT, PHASE_OUT, LAST_OUT
  );

  modport slave (
    output STEP_IN, SOL_IN, WIN_VLD_IN, DST_RDY_IN,
    input  WIN_RDY_OUT, VLD_OUT, SEL_OUT, TAP_OUT, PHASE_OUT, LAST_OUT
  );
endinterface

// File: rtl/prt_scaler_krnl_ctl.sv
// Scaler kernel sequencer: horizontal phase accumulator that time-shares one
// kernel mux by emitting four bilinear tap selects per output pixel.
module prt_scaler_krnl_ctl #(
  parameter int P_FRAC = 8
) (
  input  logic                  CLK_IN,
  input  logic                  RST_IN,
  input  logic                  EN_IN,
  prt_scaler_krnl_ctl_if.master bus
);

  localparam int AW = P_FRAC + 3;  // 3 integer bits: acc + step stays below 8.0
  localparam int SW = P_FRAC + 2;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state;
  logic [AW-1:0]     acc;
  logic [SW-1:0]     step;
  logic              rdy_q;
  logic              vld_q;
  logic              last_q;
  logic [3:0]        sel_q;
  logic [1:0]        tap_q;
  logic [P_FRAC-1:0] phase_q;

  logic              accept;
  logic              xfer;
  logic              wrap;
  logic [AW-1:0]     nacc;
  logic [AW-1:0]     emit_acc;
  logic [1:0]        emit_tap;
  logic [2:0]        emit_px;
  logic [SW-1:0]     step_in_nz;

  assign accept     = (state == S_IDLE) & bus.WIN_VLD_IN & rdy_q;
  assign xfer       = vld_q & bus.DST_RDY_IN;
  assign nacc       = acc + AW'(step);
  assign wrap       = (tap_q == 2'd3) & nacc[AW-1];
  assign step_in_nz = (bus.STEP_IN == '0) ? SW'(1) : bus.STEP_IN;

  // Position and tap index of the next tap to present.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    emit_acc = acc;
    emit_tap = tap_q + 2'd1;
    if (state == S_IDLE) begin
      emit_acc = bus.SOL_IN ? '0 : acc;
      emit_tap = 2'd0;
    end else if (tap_q == 2'd3) begin
      emit_acc = nacc;
      emit_tap = 2'd0;
    end
    emit_px = emit_acc[AW-1:P_FRAC] + {2'b00, emit_tap[0]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state   <= S_IDLE;
      acc     <= '0;
      step    <= SW'(1) << P_FRAC;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      sel_q   <= '0;
      tap_q   <= '0;
      phase_q <= '0;
    end else if (!EN_IN) begin
      // Abort discards any partially emitted pixel.
      state  <= S_IDLE;
      acc    <= '0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (xfer && wrap) begin
      // Window exhausted: carry the fractional overshoot into the next window.
      acc    <= {1'b0, nacc[AW-2:0]};
      state  <= S_IDLE;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (accept || xfer) begin
      if (accept) begin
        state <= S_RUN;
        rdy_q <= 1'b0;
        if (bus.SOL_IN) step <= step_in_nz;
      end
      acc     <= emit_acc;
      vld_q   <= 1'b1;
      sel_q   <= {emit_tap[1], emit_px};
      tap_q   <= emit_tap;
      phase_q <= emit_acc[P_FRAC-1:0];
      last_q  <= (emit_tap == 2'd3);
    end else if (state == S_IDLE) begin
      rdy_q <= 1'b1;
    end
  end

  assign bus.WIN_RDY_OUT = rdy_q;
  assign bus.VLD_OUT     = vld_q;
  assign bus.SEL_OUT     = sel_q;
  assign bus.TAP_OUT     = tap_q;
  assign bus.PHASE_OUT   = phase_q;
  assign bus.LAST_OUT    = last_q;

endmodule
